// File: rtl/imem_fetch_unit.sv
// Instruction-memory front end for the fetch stage.
//
// Serves if_instr for if_PC out of a 2-entry fetch buffer (E0/E1) and prefetches the
// next sequential word after every hit. A single-outstanding req/ack bus fetches missing
// words, with a watchdog that aborts a request after TIMEOUT unacknowledged cycles.
//
// Ports:
//   clock, reset  - rising-edge clock; synchronous active-high reset
//   if_PC         - fetch address from the fetch stage
//   buf_inv       - one-cycle pulse, invalidates both buffer entries
//   mem_ack       - memory accepts the request; mem_rdata valid in the same cycle
//   mem_rdata     - instruction word from memory
//   mem_req       - registered bus request, held until ack or timeout
//   mem_addr      - registered word address of the request
//   if_instr      - instruction for if_PC (NOP when not a hit)
//   fetch_stall   - high while if_PC is not available
//   bus_err       - one-cycle pulse on a request timeout
//   addr_err      - if_PC is not word aligned
module imem_fetch_unit #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] if_PC,
    input  logic        buf_inv,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] if_instr,
    output logic        fetch_stall,
    output logic        bus_err,
    output logic        addr_err
);

    typedef enum logic [1:0] {StIdle, StReq, StFill} state_e;

    state_e            state_q, state_d;
    logic [1:0]        valid_q, valid_d;
    logic [1:0][29:0]  tag_q, tag_d;
    logic [1:0][31:0]  data_q, data_d;
    logic              cur_q, cur_d;
    logic              target_q, target_d;
    logic              demand_q, demand_d;
    logic              discard_q, discard_d;
    logic              wr_ok_q, wr_ok_d;
    logic [31:0]       fill_data_q, fill_data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mem_req_q, mem_req_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic              bus_err_q, bus_err_d;

    logic [29:0] pc_tag;
    logic [1:0]  match;
    logic        hit;
    logic        hit_idx;
    logic        other_idx;
    logic [29:0] next_tag;
    logic        pf_have;
    logic        timeout_hit;

    assign pc_tag      = if_PC[31:2];
    assign addr_err    = |if_PC[1:0];
    assign match[0]    = valid_q[0] && (tag_q[0] == pc_tag);
    assign match[1]    = valid_q[1] && (tag_q[1] == pc_tag);
    assign hit         = !addr_err && (|match);
    assign hit_idx     = ~match[0];  // E0 wins when both match
    assign other_idx   = ~hit_idx;
    assign if_instr    = hit ? data_q[hit_idx] : 32'h0000_0000;
    assign fetch_stall = !hit && !addr_err;
    assign next_tag    = tag_q[hit_idx] + 30'd1;  // wraps modulo 2^30
    assign pf_have     = valid_q[other_idx] && (tag_q[other_idx] == next_tag);
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT));

    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;
    assign bus_err  = bus_err_q;

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        tag_d       = tag_q;
        data_d      = data_q;
        cur_d       = cur_q;
        target_d    = target_q;
        demand_d    = demand_q;
        discard_d   = discard_q;
        wr_ok_d     = wr_ok_q;
        fill_data_d = fill_data_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        bus_err_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (fetch_stall) begin
                    mem_req_d  = 1'b1;
                    mem_addr_d = {pc_tag, 2'b00};
                    target_d   = ~cur_q;
                    demand_d   = 1'b1;
                    discard_d  = 1'b0;
                    cnt_d      = '0;
                    state_d    = StReq;
                end else if (hit) begin
                    cur_d = hit_idx;
                    if (!pf_have) begin
                        mem_req_d  = 1'b1;
                        mem_addr_d = {next_tag, 2'b00};
                        target_d   = other_idx;
                        demand_d   = 1'b0;
                        discard_d  = 1'b0;
                        cnt_d      = '0;
                        state_d    = StReq;
                    end
                end
            end
            StReq: begin
                if (mem_ack) begin
                    mem_req_d   = 1'b0;
                    fill_data_d = mem_rdata;
                    // Data fetched across an invalidation is stale; drop it.
                    wr_ok_d     = !(buf_inv || discard_q);
                    state_d     = StFill;
                end else if (timeout_hit) begin
                    mem_req_d = 1'b0;
                    bus_err_d = 1'b1;
                    state_d   = StIdle;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (buf_inv) begin
                        discard_d = 1'b1;
                    end
                end
            end
            StFill: begin
                // The entry becomes visible on leaving FILL, so a hit first appears in IDLE.
                if (wr_ok_q && !buf_inv) begin
                    valid_d[target_q] = 1'b1;
                    tag_d[target_q]   = mem_addr_q[31:2];
                    data_d[target_q]  = fill_data_q;
                    if (demand_q) begin
                        cur_d = target_q;
                    end
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (buf_inv) begin
            valid_d = 2'b00;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            valid_q     <= 2'b00;
            tag_q       <= '0;
            data_q      <= '0;
            cur_q       <= 1'b0;
            target_q    <= 1'b0;
            demand_q    <= 1'b0;
            discard_q   <= 1'b0;
            wr_ok_q     <= 1'b0;
            fill_data_q <= '0;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            tag_q       <= tag_d;
            data_q      <= data_d;
            cur_q       <= cur_d;
            target_q    <= target_d;
            demand_q    <= demand_d;
            discard_q   <= discard_d;
            wr_ok_q     <= wr_ok_d;
            fill_data_q <= fill_data_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            bus_err_q   <= bus_err_d;
        end
    end

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Testbench for imem_fetch_unit: directed multi-cycle sequences, a vector table, and a
// randomized run checked against a word-level memory model.
module tb_imem_fetch_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] if_PC;
    logic        buf_inv;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] if_instr;
    logic        fetch_stall;
    logic        bus_err;
    logic        addr_err;

    imem_fetch_unit #(.TIMEOUT(4), .CNT_W(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .if_PC      (if_PC),
        .buf_inv    (buf_inv),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .if_instr   (if_instr),
        .fetch_stall(fetch_stall),
        .bus_err    (bus_err),
        .addr_err   (addr_err)
    );

    always #5 clock = ~clock;

    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned gen      = 0;   // memory contents version, bumped on each buf_inv
    logic        ack_en   = 1'b1;
    int          ack_lat  = 0;
    logic        rand_lat = 1'b0;
    logic        force_ack = 1'b0;
    logic [31:0] force_data = 32'h0;
    int          wait_cnt = 0;
    int          cur_lat  = 0;
    logic        req_prev = 1'b0;
    logic [31:0] req_log[$];

    // Memory image: word depends on address and on the invalidation generation.
    function automatic logic [31:0] mem_word(input logic [31:0] a, input int unsigned g);
        if (a == 32'h0 && g == 0) return 32'h2008_0001;
        return (a * 32'h9E37_79B1) ^ (g * 32'h0101_0101) ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] log_at(input int i);
        if (i < req_log.size()) return req_log[i];
        return 'x;
    endfunction

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(negedge clock);
        #1;
    endtask

    // Memory responder and request logger.
    always @(negedge clock) begin
        if (mem_req && !req_prev) req_log.push_back(mem_addr);
        req_prev = mem_req;
        if (force_ack) begin
            mem_ack   = 1'b1;
            mem_rdata = force_data;
        end else if (mem_req && ack_en && wait_cnt >= cur_lat) begin
            mem_ack   = 1'b1;
            mem_rdata = mem_word(mem_addr, gen);
            wait_cnt  = 0;
        end else begin
            mem_ack   = 1'b0;
            mem_rdata = 32'hDEAD_BEEF;
            if (mem_req) begin
                wait_cnt++;
            end else begin
                wait_cnt = 0;
                cur_lat  = rand_lat ? int'($urandom_range(0, 3)) : ack_lat;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1);
    end

    typedef struct {
        logic [31:0] pc;
        logic        exp_stall;
        logic        exp_aerr;
        logic [31:0] exp_instr;
        logic        exp_req;
    } vec_t;

    initial begin
        vec_t        tbl[6];
        logic [31:0] exp_log[9];
        int          n;
        int          hi;
        int          be;
        int          run;
        logic [31:0] pc;
        logic        prev_stall;
        logic        prev_req;
        logic        prev_ack;
        logic [31:0] prev_addr;
        int unsigned r;

        reset   = 1'b1;
        if_PC   = 32'h0;
        buf_inv = 1'b0;

        // ---- reset state and first demand miss ----
        next_cycle();
        next_cycle();
        req_log.delete();
        reset = 1'b0;
        #1;
        chk1("rst_mem_req", mem_req, 1'b0);
        chk32("rst_mem_addr", mem_addr, 32'h0);
        chk1("rst_bus_err", bus_err, 1'b0);
        chk1("rst_stall", fetch_stall, 1'b1);
        chk32("rst_instr", if_instr, 32'h0);
        n = 0;
        while (fetch_stall && n < 20) begin
            n++;
            next_cycle();
        end
        chk32("t1_stall_cycles", n, 3);
        chk32("t1_instr", if_instr, 32'h2008_0001);
        next_cycle();
        chk1("t1_pf_req", mem_req, 1'b1);
        chk32("t1_pf_addr", mem_addr, 32'h4);

        // ---- sequential stream, prefetch stays ahead ----
        next_cycle();
        next_cycle();
        for (int i = 1; i <= 3; i++) begin
            next_cycle();
            if_PC = 32'(i * 4);
            #1;
            chk1("seq_stall", fetch_stall, 1'b0);
            chk32("seq_instr", if_instr, mem_word(32'(i * 4), 0));
            next_cycle();
            next_cycle();
            next_cycle();
        end
        exp_log = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h100, 32'h104, 32'h108};
        chk32("seq_log_size", req_log.size(), 5);
        for (int i = 0; i < 5; i++) chk32("seq_log_addr", log_at(i), exp_log[i]);

        // ---- branch while prefetch outstanding; ack lands on the watchdog limit ----
        ack_lat = 4;
        next_cycle();
        if_PC = 32'h10;
        #1;
        chk32("br_hit16", if_instr, mem_word(32'h10, 0));
        next_cycle();
        if_PC = 32'h100;
        #1;
        chk1("br_stall", fetch_stall, 1'b1);
        n = 0;
        be = 0;
        while (fetch_stall && n < 40) begin
            n++;
            if (bus_err) be++;
            next_cycle();
        end
        chk32("br_stall_cycles", n, 13);
        chk32("br_no_bus_err", be, 0);
        chk32("br_instr", if_instr, mem_word(32'h100, 0));
        chk32("br_log_pf", log_at(5), 32'h14);
        chk32("br_log_dem", log_at(6), 32'h100);

        // ---- prefetch serves the demand ----
        next_cycle();
        if_PC = 32'h104;
        #1;
        chk1("pfd_stall", fetch_stall, 1'b1);
        n = 0;
        while (fetch_stall && n < 40) begin
            n++;
            next_cycle();
        end
        chk32("pfd_stall_cycles", n, 6);
        chk32("pfd_instr", if_instr, mem_word(32'h104, 0));
        next_cycle();
        chk32("pfd_next_addr", mem_addr, 32'h108);
        chk32("pfd_log_104", log_at(7), exp_log[7]);
        chk32("pfd_log_108", log_at(8), exp_log[8]);
        for (int i = 0; i < 8; i++) next_cycle();

        // ---- watchdog timeout and retry ----
        ack_en = 1'b0;
        next_cycle();
        if_PC = 32'h200;
        #1;
        chk1("to_stall", fetch_stall, 1'b1);
        next_cycle();
        chk1("to_req_rise", mem_req, 1'b1);
        hi = 0;
        be = 0;
        while (mem_req && hi < 20) begin
            hi++;
            if (bus_err) be++;
            next_cycle();
        end
        chk32("to_req_cycles", hi, 5);
        chk32("to_no_early_err", be, 0);
        chk1("to_bus_err", bus_err, 1'b1);
        chk1("to_stall_after", fetch_stall, 1'b1);
        next_cycle();
        chk1("to_bus_err_pulse", bus_err, 1'b0);
        chk1("to_retry_req", mem_req, 1'b1);
        chk32("to_retry_addr", mem_addr, 32'h200);
        ack_en  = 1'b1;
        ack_lat = 0;
        n = 0;
        be = 0;
        while (fetch_stall && n < 40) begin
            n++;
            if (bus_err) be++;
            next_cycle();
        end
        chk32("to_retry_no_err", be, 0);
        chk1("to_retry_stall", fetch_stall, 1'b0);
        chk32("to_retry_instr", if_instr, mem_word(32'h200, 0));
        for (int i = 0; i < 4; i++) next_cycle();

        // ---- vector table ----
        tbl[0] = '{32'h200, 1'b0, 1'b0, mem_word(32'h200, 0), 1'b0};
        tbl[1] = '{32'h206, 1'b0, 1'b1, 32'h0, 1'b0};
        tbl[2] = '{32'h201, 1'b0, 1'b1, 32'h0, 1'b0};
        tbl[3] = '{32'h007, 1'b0, 1'b1, 32'h0, 1'b0};
        tbl[4] = '{32'h204, 1'b0, 1'b0, mem_word(32'h204, 0), 1'b0};
        tbl[5] = '{32'h300, 1'b1, 1'b0, 32'h0, 1'b1};
        foreach (tbl[i]) begin
            next_cycle();
            if_PC = tbl[i].pc;
            #1;
            chk1("tbl_stall", fetch_stall, tbl[i].exp_stall);
            chk1("tbl_addr_err", addr_err, tbl[i].exp_aerr);
            chk32("tbl_instr", if_instr, tbl[i].exp_instr);
            chk1("tbl_req", mem_req, tbl[i].exp_req);
        end

        // ---- misaligned PC never requests ----
        next_cycle();
        if_PC = 32'h6;
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            chk1("ae_req", mem_req, 1'b0);
            chk1("ae_addr_err", addr_err, 1'b1);
            chk1("ae_stall", fetch_stall, 1'b0);
            chk32("ae_instr", if_instr, 32'h0);
        end

        // ---- buf_inv in the ack cycle ----
        ack_lat = 1;
        next_cycle();
        next_cycle();
        if_PC = 32'h40;
        #1;
        n = 0;
        while (!mem_ack && n < 10) begin
            n++;
            next_cycle();
        end
        chk1("inv_ack_seen", mem_ack, 1'b1);
        buf_inv = 1'b1;
        #1;
        chk1("inv_stall0", fetch_stall, 1'b1);
        gen++;
        next_cycle();
        buf_inv = 1'b0;
        #1;
        chk1("inv_stall_fill", fetch_stall, 1'b1);
        next_cycle();
        chk1("inv_stall_idle", fetch_stall, 1'b1);
        next_cycle();
        chk1("inv_rereq", mem_req, 1'b1);
        chk32("inv_rereq_addr", mem_addr, 32'h40);
        n = 0;
        while (fetch_stall && n < 20) begin
            n++;
            next_cycle();
        end
        chk32("inv_instr", if_instr, mem_word(32'h40, gen));

        // ---- reset mid-transaction; late ack ignored ----
        ack_lat = 3;
        next_cycle();
        if_PC = 32'h80;
        n = 0;
        while (!(mem_req && mem_addr == 32'h80) && n < 20) begin
            n++;
            next_cycle();
        end
        chk32("mrst_req_addr", mem_addr, 32'h80);
        reset = 1'b1;
        next_cycle();
        chk1("mrst_req_drop", mem_req, 1'b0);
        reset      = 1'b0;
        if_PC      = 32'h82;
        force_data = mem_word(32'h80, gen);
        force_ack  = 1'b1;
        next_cycle();
        force_ack = 1'b0;
        chk1("mrst_no_req", mem_req, 1'b0);
        if_PC = 32'h80;
        #1;
        chk1("mrst_not_written", fetch_stall, 1'b1);
        next_cycle();
        chk1("mrst_demand_req", mem_req, 1'b1);
        chk32("mrst_demand_addr", mem_addr, 32'h80);

        // ---- randomized run against the memory model ----
        reset = 1'b1;
        if_PC = 32'h0;
        next_cycle();
        next_cycle();
        reset      = 1'b0;
        rand_lat   = 1'b1;
        pc         = 32'h0;
        prev_stall = 1'b1;
        prev_req   = 1'b0;
        prev_ack   = 1'b0;
        prev_addr  = 32'h0;
        run        = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            next_cycle();
            if (!prev_stall) begin
                r = $urandom_range(0, 99);
                if (r < 70) pc = (pc & ~32'h3) + 32'h4;
                else if (r < 85) pc = $urandom_range(0, 255) * 4;
                else if (r < 92) pc = (pc & ~32'h3) + $urandom_range(1, 3);
                else if (r < 95) pc = 32'hFFFF_FFF8;
            end
            if_PC   = pc;
            buf_inv = ($urandom_range(0, 39) == 0);
            #1;
            chk1("rnd_addr_err", addr_err, pc[1:0] != 2'b00);
            if (pc[1:0] != 2'b00) begin
                chk1("rnd_ae_stall", fetch_stall, 1'b0);
                chk32("rnd_ae_instr", if_instr, 32'h0);
            end else if (!fetch_stall) begin
                chk32("rnd_instr", if_instr, mem_word(pc, gen));
            end
            run = fetch_stall ? run + 1 : 0;
            chk1("rnd_stall_bound", run <= 40, 1'b1);
            chk1("rnd_no_bus_err", bus_err, 1'b0);
            chk32("rnd_addr_align", {30'h0, mem_addr[1:0]}, 32'h0);
            if (prev_req && !prev_ack) begin
                chk1("rnd_req_held", mem_req, 1'b1);
                chk32("rnd_addr_held", mem_addr, prev_addr);
            end else if (prev_req && prev_ack) begin
                chk1("rnd_req_drop", mem_req, 1'b0);
            end
            if (buf_inv) gen++;
            prev_stall = fetch_stall;
            prev_req   = mem_req;
            prev_ack   = mem_ack;
            prev_addr  = mem_addr;
        end
        buf_inv = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
